uart_frame_engine: RTL and testbench

Parametrised byte-framing engine between the `uart_rx`/`uart_tx` byte cores and the mining control FSM. Receive side assembles `RX_BYTES` consecutive bytes into one wide frame, with an inter-byte timeout. Transmit side serialises a latched `TX_BYTES` word out one byte at a time using the `uart_tx` handshake. Full duplex; completion is reported on the last byte, not on an extra byte.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_ser.sv | 84 ++++++++
 rtl/uart_frame_engine.sv | 115 +++++++++++
 tb/tb_uart_frame_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared state types, default sizing and counter-width helper for the UART byte-framing engine.
package uart_frame_pkg;

  typedef enum logic {
    RX_IDLE,
    RX_COLLECT
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT
  } tx_state_t;

  localparam int unsigned DEF_RX_BYTES       = 76;
  localparam int unsigned DEF_TX_BYTES       = 4;
  localparam bit          DEF_MSB_FIRST      = 1'b1;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100_000;

  // Bits needed to hold 0..max_val; never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// TX serialiser: latches a TX_BYTES word on start, strobes one byte per uart_tx handshake.
// First tx_dv one cycle after start unless tx_active is high; tx_start is ignored while busy.
module uart_frame_ser
  import uart_frame_pkg::*;
#(
  parameter int unsigned TX_BYTES  = DEF_TX_BYTES,
  parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  tx_start,
  input  logic [TX_BYTES*8-1:0] tx_frame,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  output logic                  tx_busy,
  output logic                  tx_frame_done
);

  localparam int unsigned      TX_W     = TX_BYTES * 8;
  localparam int unsigned      CNT_W    = cnt_width(TX_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_BYTES - 1);

  tx_state_t        state_q;
  logic [TX_W-1:0]  shift_q;
  logic [TX_W-1:0]  shift_d;
  logic [CNT_W-1:0] tx_cnt_q;
  logic             tx_dv_q;
  logic             tx_frame_done_q;

  // The byte on the wire always sits at the outgoing end of the shift register.
  always_comb begin
    shift_d = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= TX_IDLE;
      shift_q         <= '0;
      tx_cnt_q        <= '0;
      tx_dv_q         <= 1'b0;
      tx_frame_done_q <= 1'b0;
    end else begin
      tx_dv_q         <= 1'b0;
      tx_frame_done_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          if (tx_start) begin
            shift_q  <= tx_frame;
            tx_cnt_q <= '0;
            state_q  <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!tx_active) begin
            tx_dv_q <= 1'b1;
            state_q <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
            shift_q <= shift_d;
            if (tx_cnt_q == CNT_LAST) begin
              tx_cnt_q        <= '0;
              tx_frame_done_q <= 1'b1;
              state_q         <= TX_IDLE;
            end else begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
              state_q  <= TX_LOAD;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_dv         = tx_dv_q;
  assign tx_byte       = MSB_FIRST ? shift_q[TX_W-1 -: 8] : shift_q[7:0];
  assign tx_busy       = (state_q != TX_IDLE);
  assign tx_frame_done = tx_frame_done_q;

endmodule

// File: rtl/uart_frame_engine.sv
// Full-duplex UART framer: RX gathers RX_BYTES into a frame (valid 1 cycle after last byte, inter-byte
// timeout); TX is delegated to uart_frame_ser. No backpressure on RX; TX paced by tx_active/tx_done.
module uart_frame_engine
  import uart_frame_pkg::*;
#(
  parameter int unsigned RX_BYTES       = DEF_RX_BYTES,
  parameter int unsigned TX_BYTES       = DEF_TX_BYTES,
  parameter bit          MSB_FIRST      = DEF_MSB_FIRST,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  rx_enable,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  output logic [RX_BYTES*8-1:0] rx_frame,
  output logic                  rx_frame_valid,
  output logic                  rx_timeout,
  input  logic                  tx_start,
  input  logic [TX_BYTES*8-1:0] tx_frame,
  output logic                  tx_dv,
  output logic [7:0]            tx_byte,
  input  logic                  tx_active,
  input  logic                  tx_done,
  output logic                  tx_busy,
  output logic                  tx_frame_done
);

  localparam int unsigned         RX_W      = RX_BYTES * 8;
  localparam int unsigned         RX_CNT_W  = cnt_width(RX_BYTES);
  localparam int unsigned         IDLE_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [RX_CNT_W-1:0] RX_LAST   = RX_CNT_W'(RX_BYTES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  rx_state_t           rx_state_q;
  logic [RX_W-1:0]     shadow_q;
  logic [RX_W-1:0]     shadow_d;
  logic [RX_W-1:0]     rx_frame_q;
  logic [RX_CNT_W-1:0] rx_cnt_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic                rx_frame_valid_q;
  logic                rx_timeout_q;

  // After RX_BYTES shifts every stale byte has left the shadow, so it never needs clearing.
  always_comb begin
    if (MSB_FIRST) begin
      shadow_d = (shadow_q << 8) | RX_W'(rx_byte);
    end else begin
      shadow_d = (shadow_q >> 8) | (RX_W'(rx_byte) << (RX_W - 8));
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q       <= RX_IDLE;
      shadow_q         <= '0;
      rx_frame_q       <= '0;
      rx_cnt_q         <= '0;
      idle_cnt_q       <= '0;
      rx_frame_valid_q <= 1'b0;
      rx_timeout_q     <= 1'b0;
    end else begin
      rx_frame_valid_q <= 1'b0;
      rx_timeout_q     <= 1'b0;
      if (!rx_enable) begin
        rx_state_q <= RX_IDLE;
        rx_cnt_q   <= '0;
        idle_cnt_q <= '0;
      end else if (rx_dv) begin
        // A byte arriving on the expiry cycle still counts: it outranks the timeout.
        shadow_q   <= shadow_d;
        idle_cnt_q <= '0;
        if (rx_cnt_q == RX_LAST) begin
          rx_frame_q       <= shadow_d;
          rx_frame_valid_q <= 1'b1;
          rx_cnt_q         <= '0;
          rx_state_q       <= RX_IDLE;
        end else begin
          rx_cnt_q   <= rx_cnt_q + 1'b1;
          rx_state_q <= RX_COLLECT;
        end
      end else if (rx_state_q == RX_COLLECT && TIMEOUT_CYCLES != 0) begin
        if (idle_cnt_q == IDLE_LAST) begin
          rx_timeout_q <= 1'b1;
          idle_cnt_q   <= '0;
          rx_cnt_q     <= '0;
          rx_state_q   <= RX_IDLE;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end
    end
  end

  assign rx_frame       = rx_frame_q;
  assign rx_frame_valid = rx_frame_valid_q;
  assign rx_timeout     = rx_timeout_q;

  uart_frame_ser #(
    .TX_BYTES (TX_BYTES),
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk          (clk),
    .rst_i        (rst_i),
    .tx_start     (tx_start),
    .tx_frame     (tx_frame),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .tx_dv        (tx_dv),
    .tx_byte      (tx_byte),
    .tx_busy      (tx_busy),
    .tx_frame_done(tx_frame_done)
  );

endmodule

// File: tb/tb_uart_frame_engine.sv
// MSB- and LSB-first engines share stimulus; a queue-based reference model predicts every output each cycle.
module tb_uart_frame_engine;

  localparam int RXB = 4;
  localparam int TXB = 4;
  localparam int TO  = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, rx_enable, rx_dv, tx_start, tx_active, tx_done;
  logic [7:0]  rx_byte;
  logic [31:0] tx_frame;

  logic [31:0] rx_frame_m, rx_frame_l;
  logic        rx_frame_valid_m, rx_frame_valid_l, rx_timeout_m, rx_timeout_l;
  logic        tx_dv_m, tx_dv_l, tx_busy_m, tx_busy_l, tx_frame_done_m, tx_frame_done_l;
  logic [7:0]  tx_byte_m, tx_byte_l;

  uart_frame_engine #(.RX_BYTES(RXB), .TX_BYTES(TXB), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) dut_m (
    .clk(clk), .rst_i(rst_i), .rx_enable(rx_enable), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .rx_frame(rx_frame_m), .rx_frame_valid(rx_frame_valid_m), .rx_timeout(rx_timeout_m),
    .tx_start(tx_start), .tx_frame(tx_frame), .tx_dv(tx_dv_m), .tx_byte(tx_byte_m),
    .tx_active(tx_active), .tx_done(tx_done), .tx_busy(tx_busy_m), .tx_frame_done(tx_frame_done_m));

  uart_frame_engine #(.RX_BYTES(RXB), .TX_BYTES(TXB), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) dut_l (
    .clk(clk), .rst_i(rst_i), .rx_enable(rx_enable), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .rx_frame(rx_frame_l), .rx_frame_valid(rx_frame_valid_l), .rx_timeout(rx_timeout_l),
    .tx_start(tx_start), .tx_frame(tx_frame), .tx_dv(tx_dv_l), .tx_byte(tx_byte_l),
    .tx_active(tx_active), .tx_done(tx_done), .tx_busy(tx_busy_l), .tx_frame_done(tx_frame_done_l));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0]  m_rxq[$];
  int          m_age = 0;
  logic [7:0]  m_txq_m[$], m_txq_l[$];
  bit          m_busy = 1'b0, m_load = 1'b0;
  logic        e_rx_vld = 1'b0, e_rx_to = 1'b0, e_tx_dv = 1'b0, e_tx_done = 1'b0;
  logic [31:0] e_frame_m = '0, e_frame_l = '0;
  logic [7:0]  e_byte_m = '0, e_byte_l = '0;

  // uart_tx stand-in
  int u_cnt = 0, u_tail = 0, tail_max = 0;
  logic [7:0] obs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit was_busy;
    e_rx_vld = 1'b0; e_rx_to = 1'b0; e_tx_dv = 1'b0; e_tx_done = 1'b0;
    if (rst_i) begin
      m_rxq.delete(); m_age = 0; m_txq_m.delete(); m_txq_l.delete();
      m_busy = 1'b0; m_load = 1'b0; e_frame_m = '0; e_frame_l = '0;
      return;
    end
    if (!rx_enable) begin
      m_rxq.delete(); m_age = 0;
    end else if (rx_dv) begin
      m_rxq.push_back(rx_byte); m_age = 0;
      if (m_rxq.size() == RXB) begin
        e_frame_m = '0; e_frame_l = '0;
        for (int i = 0; i < RXB; i++) begin
          e_frame_m = (e_frame_m << 8) | {24'h0, m_rxq[i]};
          e_frame_l = e_frame_l | ({24'h0, m_rxq[i]} << (8 * i));
        end
        e_rx_vld = 1'b1;
        m_rxq.delete();
      end
    end else if (m_rxq.size() != 0) begin
      m_age++;
      if (m_age == TO) begin e_rx_to = 1'b1; m_rxq.delete(); m_age = 0; end
    end
    was_busy = m_busy;
    if (m_load) begin
      if (!tx_active) begin
        e_tx_dv = 1'b1; e_byte_m = m_txq_m[0]; e_byte_l = m_txq_l[0]; m_load = 1'b0;
      end
    end else if (m_busy && tx_done) begin
      void'(m_txq_m.pop_front()); void'(m_txq_l.pop_front());
      if (m_txq_m.size() == 0) begin e_tx_done = 1'b1; m_busy = 1'b0; end
      else m_load = 1'b1;
    end
    if (!was_busy && tx_start) begin
      m_busy = 1'b1; m_load = 1'b1;
      for (int i = 0; i < TXB; i++) begin
        m_txq_m.push_back(tx_frame[8*(TXB-1-i) +: 8]);
        m_txq_l.push_back(tx_frame[8*i +: 8]);
      end
    end
  endtask

  task automatic compare_all();
    check("rx_valid_m", 32'(rx_frame_valid_m), 32'(e_rx_vld));
    check("rx_valid_l", 32'(rx_frame_valid_l), 32'(e_rx_vld));
    check("rx_timeout_m", 32'(rx_timeout_m), 32'(e_rx_to));
    check("rx_timeout_l", 32'(rx_timeout_l), 32'(e_rx_to));
    check("rx_frame_m", rx_frame_m, e_frame_m);
    check("rx_frame_l", rx_frame_l, e_frame_l);
    check("tx_dv_m", 32'(tx_dv_m), 32'(e_tx_dv));
    check("tx_dv_l", 32'(tx_dv_l), 32'(e_tx_dv));
    check("tx_busy_m", 32'(tx_busy_m), 32'(m_busy));
    check("tx_busy_l", 32'(tx_busy_l), 32'(m_busy));
    check("tx_fdone_m", 32'(tx_frame_done_m), 32'(e_tx_done));
    check("tx_fdone_l", 32'(tx_frame_done_l), 32'(e_tx_done));
    if (e_tx_dv) begin
      check("tx_byte_m", 32'(tx_byte_m), 32'(e_byte_m));
      check("tx_byte_l", 32'(tx_byte_l), 32'(e_byte_l));
    end
    if (tx_dv_m) obs.push_back(tx_byte_m);
  endtask

  // uart_tx: busy after each strobe, tx_done 10 cycles later, optional lingering busy tail.
  task automatic uart_model();
    tx_done = 1'b0;
    if (rst_i) begin
      u_cnt = 0; u_tail = 0; tx_active = 1'b0;
    end else if (tx_dv_m) begin
      u_cnt = 1; tx_active = 1'b1;
    end else if (u_cnt > 0) begin
      u_cnt++;
      if (u_cnt == 10) begin
        tx_done = 1'b1; u_cnt = 0;
        u_tail = $urandom_range(0, tail_max);
        tx_active = (u_tail != 0);
      end
    end else if (u_tail > 0) begin
      u_tail--; tx_active = (u_tail != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    uart_model();
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    rx_dv = 1'b1; rx_byte = b;
    tick();
    rx_dv = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    logic [7:0] exp_seq[4];
    int  to_seen, dv_n, after_n;
    bit  seen, dense;
    exp_seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rst_i = 1'b1; rx_enable = 1'b0; rx_dv = 1'b0; rx_byte = '0;
    tx_start = 1'b0; tx_frame = '0; tx_active = 1'b0; tx_done = 1'b0;
    repeat (3) tick();
    check("reset_rx_frame", rx_frame_m, 32'h0);
    check("reset_tx_busy", 32'(tx_busy_m), 32'h0);
    check("reset_tx_byte", 32'(tx_byte_m), 32'h0);
    rst_i = 1'b0; rx_enable = 1'b1;
    tick();

    send_rx(8'h11, 1); send_rx(8'h22, 2); send_rx(8'h33, 0); send_rx(8'h44, 0);
    check("rx_msb_frame", rx_frame_m, 32'h11223344);
    check("rx_lsb_frame", rx_frame_l, 32'h44332211);
    check("rx_valid_pulse", 32'(rx_frame_valid_m), 32'h1);
    tick();
    check("rx_valid_single", 32'(rx_frame_valid_m), 32'h0);
    send_rx(8'h55, 3);
    send_rx(8'h66, 0);
    to_seen = 0;
    repeat (60) begin tick(); if (rx_timeout_m) to_seen++; end
    check("rx_timeout_once", 32'(to_seen), 32'h1);
    check("rx_timeout_keeps_frame", rx_frame_m, 32'h11223344);
    // each following byte lands exactly on the expiry cycle
    send_rx(8'hA0, 49); send_rx(8'hA1, 49); send_rx(8'hA2, 49); send_rx(8'hA3, 0);
    check("rx_after_timeout", rx_frame_m, 32'hA0A1A2A3);
    check("rx_after_timeout_l", rx_frame_l, 32'hA3A2A1A0);

    send_rx(8'h01, 0); send_rx(8'h02, 0); send_rx(8'h03, 0);
    rx_enable = 1'b0; rx_dv = 1'b1; rx_byte = 8'h04;
    tick();
    rx_dv = 1'b0;
    check("abort_rx_cnt", 32'(dut_m.rx_cnt_q), 32'h0);
    rx_enable = 1'b1;
    tick();
    send_rx(8'hC1, 0); send_rx(8'hC2, 0); send_rx(8'hC3, 0); send_rx(8'hC4, 2);
    check("abort_then_frame", rx_frame_m, 32'hC1C2C3C4);

    obs.delete();
    tx_frame = 32'hDEADBEEF; tx_start = 1'b1;
    tick();
    tx_start = 1'b0; tx_frame = 32'h0;
    repeat (15) tick();
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin tick(); if (tx_frame_done_m) seen = 1'b1; end
    check("tx_frame_done_seen", 32'(seen), 32'h1);
    check("tx_byte_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("tx_seq%0d", i), 32'(obs[i]), 32'(exp_seq[i]));

    tx_frame = 32'h12345678; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("b2b_busy", 32'(tx_busy_m), 32'h1);
    tick();
    check("b2b_first_dv", 32'(tx_dv_m), 32'h1);
    check("b2b_first_byte", 32'(tx_byte_m), 32'h12);
    dv_n = 1;
    for (int i = 0; i < 100 && dv_n < 2; i++) begin tick(); if (tx_dv_m) dv_n++; end
    check("reach_byte2", 32'(dv_n), 32'd2);
    rst_i = 1'b1;
    #1;
    check("rst_tx_dv", 32'(tx_dv_m), 32'h0);
    check("rst_tx_busy", 32'(tx_busy_m), 32'h0);
    check("rst_tx_frame_done", 32'(tx_frame_done_m), 32'h0);
    tick();
    rst_i = 1'b0;
    check("rst_rx_frame", rx_frame_m, 32'h0);
    after_n = 0;
    repeat (40) begin tick(); if (tx_dv_m) after_n++; end
    check("rst_no_more_bytes", 32'(after_n), 32'h0);

    tail_max = 2;
    dense = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) dense = ($urandom_range(0, 1) == 1);
      rx_dv     = dense ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      rx_byte   = 8'($urandom);
      rx_enable = ($urandom_range(0, 299) != 0);
      tx_start  = ($urandom_range(0, 7) == 0);
      tx_frame  = $urandom;
      if (tx_start && u_cnt == 0 && u_tail == 0 && !tx_active && $urandom_range(0, 3) == 0) begin
        u_tail = $urandom_range(1, 3); tx_active = 1'b1;
      end
      tick();
    end
    rx_dv = 1'b0; tx_start = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
